// File: rtl/memory_pkg.sv
// Shared types and tree-PLRU helpers for cache replacement logic.
// The PLRU helpers work on trees of up to PLRU_MAX_WAY ways. A smaller tree sits in the low bits.
package memory_pkg;

   typedef enum logic [1:0] {
      REPL_RR,
      REPL_PLRU,
      REPL_RAND
   } replacement_policy_e;

   localparam int PLRU_MAX_WAY = 32;
   localparam int PLRU_MAX_LVL = 5;

   typedef logic [PLRU_MAX_WAY-2:0] plru_tree_t;

   function automatic int plru_levels(input int n_way);
      int lv;
      lv = 0;
      for (int i = 0; i < PLRU_MAX_LVL; i++) begin
         if ((1 << i) < n_way) lv++;
      end
      return lv;
   endfunction

   // Walk from the root. A set bit sends the walk to the high half.
   function automatic int plru_victim(input plru_tree_t tree, input int n_way);
      logic [4:0] node;
      int         way;
      int         lv;
      node = '0;
      way  = 0;
      lv   = plru_levels(n_way);
      for (int i = 0; i < PLRU_MAX_LVL; i++) begin
         if (i < lv) begin
            if (tree[node]) begin
               way  = 2 * way + 1;
               node = 5'({node, 1'b0} + 6'd2);
            end else begin
               way  = 2 * way;
               node = 5'({node, 1'b0} + 6'd1);
            end
         end
      end
      return way;
   endfunction

   function automatic plru_tree_t plru_touch(input plru_tree_t tree, input int way,
                                             input int n_way);
      plru_tree_t t;
      logic [4:0] node;
      logic       b;
      int         lv;
      t    = tree;
      node = '0;
      lv   = plru_levels(n_way);
      for (int i = 0; i < PLRU_MAX_LVL; i++) begin
         if (i < lv) begin
            b       = ((way >> (lv - 1 - i)) & 1) != 0;
            t[node] = ~b;
            node    = b ? 5'({node, 1'b0} + 6'd2) : 5'({node, 1'b0} + 6'd1);
         end
      end
      return t;
   endfunction

endpackage

// File: rtl/cache_replacement_unit_if.sv
// Controller-side bus of the replacement unit: hit touches, victim requests, victim results.
interface cache_replacement_unit_if #(
   parameter int N_WAY = 4,
   parameter int N_SET = 64
);
   localparam int SET_W = $clog2(N_SET);
   localparam int IDX_W = $clog2(N_WAY);

   logic             flush_i;
   logic             access_valid_i;
   logic [SET_W-1:0] access_set_i;
   logic [N_WAY-1:0] access_way_i;
   logic             victim_req_i;
   logic [SET_W-1:0] victim_set_i;
   logic [N_WAY-1:0] valid_vec_i;
   logic             victim_valid_o;
   logic [N_WAY-1:0] victim_way_o;
   logic [IDX_W-1:0] victim_idx_o;

   modport master (
      output flush_i, access_valid_i, access_set_i, access_way_i,
      output victim_req_i, victim_set_i, valid_vec_i,
      input  victim_valid_o, victim_way_o, victim_idx_o
   );

   modport slave (
      input  flush_i, access_valid_i, access_set_i, access_way_i,
      input  victim_req_i, victim_set_i, valid_vec_i,
      output victim_valid_o, victim_way_o, victim_idx_o
   );

endinterface

// File: rtl/repl_lfsr16.sv
// 16-bit Fibonacci LFSR (x^16+x^14+x^13+x^11+1). It steps only when advance_i is high.
module repl_lfsr16 #(
   parameter logic [15:0] SEED = 16'hACE1
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        advance_i,
   output logic [15:0] value_o
);

   logic [15:0] lfsr_q;
   logic        feedback;

   assign feedback = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         lfsr_q <= SEED;
      end else if (advance_i) begin
         lfsr_q <= {lfsr_q[14:0], feedback};
      end
   end

   assign value_o = lfsr_q;

endmodule

// File: rtl/cache_replacement_unit.sv
// Per-set victim selector for set-associative caches.
// Invalid ways are filled first. Otherwise the victim comes from the elaboration-time policy.
module cache_replacement_unit
   import memory_pkg::*;
#(
   parameter int                  N_WAY     = 4,
   parameter int                  N_SET     = 64,
   parameter replacement_policy_e POLICY    = REPL_PLRU,
   parameter logic [15:0]         LFSR_SEED = 16'hACE1
) (
   input logic                     clk_i,
   input logic                     rst_ni,
   cache_replacement_unit_if.slave bus
);

   localparam int SET_W = $clog2(N_SET);
   localparam int IDX_W = $clog2(N_WAY);

   logic             any_invalid;
   logic [IDX_W-1:0] invalid_idx;
   logic [IDX_W-1:0] access_idx;
   logic [IDX_W-1:0] policy_idx;
   logic [IDX_W-1:0] victim_idx;
   logic             policy_hit;

   // Stage p0: pick the victim from the state held before this cycle's updates
   always_comb begin
      any_invalid = 1'b0;
      invalid_idx = '0;
      for (int k = N_WAY - 1; k >= 0; k--) begin
         if (!bus.valid_vec_i[k]) begin
            any_invalid = 1'b1;
            invalid_idx = IDX_W'(k);
         end
      end
   end

   always_comb begin
      access_idx = '0;
      for (int k = 0; k < N_WAY; k++) begin
         if (bus.access_way_i[k]) access_idx = access_idx | IDX_W'(k);
      end
   end

   assign policy_hit = bus.victim_req_i && !any_invalid;
   assign victim_idx = any_invalid ? invalid_idx : policy_idx;

   if (POLICY == REPL_RR) begin : g_rr
      logic [IDX_W-1:0] rr_q [N_SET];
      logic             unused_rr;

      assign policy_idx = rr_q[bus.victim_set_i];
      assign unused_rr  = ^{bus.access_valid_i, bus.access_set_i, access_idx};

      always_ff @(posedge clk_i or negedge rst_ni) begin
         if (!rst_ni) begin
            for (int s = 0; s < N_SET; s++) rr_q[s] <= '0;
         end else if (bus.flush_i) begin
            for (int s = 0; s < N_SET; s++) rr_q[s] <= '0;
         end else if (policy_hit) begin
            rr_q[bus.victim_set_i] <= rr_q[bus.victim_set_i] + IDX_W'(1);
         end
      end
   end else if (POLICY == REPL_PLRU) begin : g_plru
      localparam int TREE_W = N_WAY - 1;
      logic [TREE_W-1:0] plru_q [N_SET];
      logic [TREE_W-1:0] plru_d [N_SET];
      plru_tree_t        victim_tree;
      plru_tree_t        t;

      always_comb begin
         victim_tree               = '0;
         victim_tree[TREE_W-1:0]   = plru_q[bus.victim_set_i];
      end

      assign policy_idx = IDX_W'(plru_victim(victim_tree, N_WAY));

      // The victim touch comes second, so it wins on nodes shared with a same-set hit.
      always_comb begin
         t = '0;
         for (int s = 0; s < N_SET; s++) begin
            t             = '0;
            t[TREE_W-1:0] = plru_q[s];
            if (bus.access_valid_i && bus.access_set_i == SET_W'(s)) begin
               t = plru_touch(t, int'(access_idx), N_WAY);
            end
            if (bus.victim_req_i && bus.victim_set_i == SET_W'(s)) begin
               t = plru_touch(t, int'(victim_idx), N_WAY);
            end
            plru_d[s] = t[TREE_W-1:0];
         end
      end

      always_ff @(posedge clk_i or negedge rst_ni) begin
         if (!rst_ni) begin
            for (int s = 0; s < N_SET; s++) plru_q[s] <= '0;
         end else if (bus.flush_i) begin
            for (int s = 0; s < N_SET; s++) plru_q[s] <= '0;
         end else begin
            for (int s = 0; s < N_SET; s++) plru_q[s] <= plru_d[s];
         end
      end
   end else begin : g_rand
      logic [15:0] lfsr_value;
      logic        unused_rand;

      repl_lfsr16 #(
         .SEED (LFSR_SEED)
      ) u_lfsr (
         .clk_i     (clk_i),
         .rst_ni    (rst_ni),
         .advance_i (policy_hit),
         .value_o   (lfsr_value)
      );

      assign policy_idx  = lfsr_value[IDX_W-1:0];
      assign unused_rand = ^{lfsr_value[15:IDX_W], bus.access_valid_i, bus.access_set_i,
                             access_idx, bus.flush_i};
   end

   // Stage p1: registered result, held while no request is pending
   logic             vld_p1;
   logic [N_WAY-1:0] victim_way_p1;
   logic [IDX_W-1:0] victim_idx_p1;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         vld_p1        <= 1'b0;
         victim_way_p1 <= '0;
         victim_idx_p1 <= '0;
      end else begin
         vld_p1 <= bus.victim_req_i;
         if (bus.victim_req_i) begin
            victim_idx_p1 <= victim_idx;
            victim_way_p1 <= N_WAY'(1) << victim_idx;
         end
      end
   end

   assign bus.victim_valid_o = vld_p1;
   assign bus.victim_way_o   = victim_way_p1;
   assign bus.victim_idx_o   = victim_idx_p1;

   a_access_onehot: assert property (@(posedge clk_i) disable iff (!rst_ni)
      bus.access_valid_i |-> $onehot(bus.access_way_i));

endmodule

// File: tb/tb_cache_replacement_unit.sv
// Scoreboard bench: the RR, PLRU and RAND variants run side by side and are checked against a behavioural model.
module tb_cache_replacement_unit;
   import memory_pkg::*;

   localparam int          NW   = 4;
   localparam int          NS   = 64;
   localparam int          NP   = 3;
   localparam logic [15:0] SEED = 16'hACE1;
   localparam logic [3:0]  ALL  = 4'hF;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic       flush = 1'b0, acc_v = 1'b0, req = 1'b0;
   logic [5:0] acc_s = '0, vset = '0;
   logic [3:0] acc_w = 4'b0001, vvec = ALL;

   logic       out_v [NP];
   logic [3:0] out_w [NP];
   logic [1:0] out_i [NP];

   for (genvar g = 0; g < NP; g++) begin : g_dut
      cache_replacement_unit_if #(.N_WAY(NW), .N_SET(NS)) bus ();
      assign bus.flush_i        = flush;
      assign bus.access_valid_i = acc_v;
      assign bus.access_set_i   = acc_s;
      assign bus.access_way_i   = acc_w;
      assign bus.victim_req_i   = req;
      assign bus.victim_set_i   = vset;
      assign bus.valid_vec_i    = vvec;
      assign out_v[g] = bus.victim_valid_o;
      assign out_w[g] = bus.victim_way_o;
      assign out_i[g] = bus.victim_idx_o;
      cache_replacement_unit #(
         .N_WAY(NW), .N_SET(NS), .POLICY(replacement_policy_e'(g)), .LFSR_SEED(SEED)
      ) u_dut (
         .clk_i  (clk),
         .rst_ni (rst_n),
         .bus    (bus)
      );
   end

   // Reference model state: RR pointers, PLRU trees, LFSR value.
   int          rr_ptr [NS];
   bit          tree [NS][NW-1];
   logic [15:0] lfsr_m;
   int          exp_q [NP][$];
   int          last_exp [NP];
   int          last_way [NP];
   int          n_cmp = 0, n_bad = 0;

   function automatic string pname(input int d);
      return (d == 0) ? "rr" : (d == 1) ? "plru" : "rand";
   endfunction

   function automatic int plru_pick(input int s);
      int node = 0, lo = 0, hi = NW, mid;
      while (hi - lo > 1) begin
         mid = (lo + hi) / 2;
         if (tree[s][node]) begin lo = mid; node = 2 * node + 2; end
         else begin hi = mid; node = 2 * node + 1; end
      end
      return lo;
   endfunction

   function automatic void plru_mark(input int s, input int w);
      int node = 0, lo = 0, hi = NW, mid;
      while (hi - lo > 1) begin
         mid = (lo + hi) / 2;
         if (w < mid) begin tree[s][node] = 1'b1; hi = mid; node = 2 * node + 1; end
         else begin tree[s][node] = 1'b0; lo = mid; node = 2 * node + 2; end
      end
   endfunction

   function automatic void lfsr_adv();
      int fb;
      fb     = ((lfsr_m >> 15) ^ (lfsr_m >> 13) ^ (lfsr_m >> 12) ^ (lfsr_m >> 10)) & 1;
      lfsr_m = 16'((lfsr_m << 1) | 16'(fb));
   endfunction

   function automatic void clear_sets();
      for (int s = 0; s < NS; s++) begin
         rr_ptr[s] = 0;
         for (int n = 0; n < NW - 1; n++) tree[s][n] = 1'b0;
      end
   endfunction

   function automatic void reset_model();
      clear_sets();
      lfsr_m = SEED;
      for (int d = 0; d < NP; d++) begin
         exp_q[d].delete();
         last_exp[d] = 0;
         last_way[d] = 0;
      end
   endfunction

   function automatic void chk(input string name, input int act, input int req_v);
      n_cmp++;
      if (act != req_v) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", name, act, req_v);
      end
   endfunction

   task automatic check_reset();
      for (int d = 0; d < NP; d++) begin
         chk({pname(d), " reset valid"}, int'(out_v[d]), 0);
         chk({pname(d), " reset way"}, int'(out_w[d]), 0);
         chk({pname(d), " reset idx"}, int'(out_i[d]), 0);
      end
   endtask

   // One cycle of stimulus. A non-negative e_* replaces the model's answer with a hand-derived one.
   task automatic step(input bit av, input int as, input int aw, input bit rq, input int vs,
                       input logic [3:0] vv, input bit fl,
                       input int e_rr = -1, input int e_plru = -1, input int e_rand = -1);
      int lowz, mv, pol [NP], ovr [NP];
      @(posedge clk);
      #1;
      acc_v = av; acc_s = 6'(as); acc_w = 4'(1 << aw);
      req = rq; vset = 6'(vs); vvec = vv; flush = fl;
      ovr[0] = e_rr; ovr[1] = e_plru; ovr[2] = e_rand;
      lowz = -1;
      for (int k = NW - 1; k >= 0; k--) if (!vv[k]) lowz = k;
      mv = 0;
      if (rq) begin
         pol[0] = rr_ptr[vs];
         pol[1] = plru_pick(vs);
         pol[2] = int'(lfsr_m) % NW;
         for (int d = 0; d < NP; d++)
            exp_q[d].push_back((ovr[d] >= 0) ? ovr[d] : ((lowz >= 0) ? lowz : pol[d]));
         mv = (lowz >= 0) ? lowz : pol[1];
      end
      if (av) plru_mark(as, aw);
      if (rq) plru_mark(vs, mv);
      if (rq && lowz < 0) begin
         rr_ptr[vs] = (rr_ptr[vs] + 1) % NW;
         lfsr_adv();
      end
      if (fl) clear_sets();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 0, 0, 1'b0, 0, ALL, 1'b0);
   endtask

   always @(negedge clk) begin
      int e;
      if (rst_n) begin
         for (int d = 0; d < NP; d++) begin
            n_cmp++;
            if (out_v[d]) begin
               if (exp_q[d].size() == 0) begin
                  n_bad++;
                  $display("FAIL %s spurious: victim_valid with no request, idx=%0d", pname(d), out_i[d]);
               end else begin
                  e = exp_q[d].pop_front();
                  last_exp[d] = e;
                  last_way[d] = 1 << e;
                  if (int'(out_i[d]) != e || int'(out_w[d]) != (1 << e)) begin
                     n_bad++;
                     $display("FAIL %s victim: idx=%0d way=%b, expected idx=%0d way=%b",
                              pname(d), out_i[d], out_w[d], e, 4'(1 << e));
                  end
               end
            end else if (int'(out_i[d]) != last_exp[d] || int'(out_w[d]) != last_way[d]) begin
               n_bad++;
               $display("FAIL %s hold: idx=%0d way=%b, expected idx=%0d way=%b",
                        pname(d), out_i[d], out_w[d], last_exp[d], 4'(last_way[d]));
            end
         end
      end
   end

   initial begin
      reset_model();
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      check_reset();

      // PLRU touch sequence, invalid-first, RR pointer and LFSR untouched by invalid-first
      step(0, 0, 0, 1, 3, ALL, 0, 0, 0, 1);
      step(1, 3, 0, 0, 0, ALL, 0);
      step(0, 0, 0, 1, 3, ALL, 0, 1, 2, 3);
      step(1, 3, 2, 0, 0, ALL, 0);
      step(0, 0, 0, 1, 3, ALL, 0, 2, 1, 3);
      step(0, 0, 0, 1, 3, 4'b1010, 0, 0, 0, 0);
      step(0, 0, 0, 1, 3, 4'b0111, 0, 3, 3, 3);
      step(0, 0, 0, 1, 3, ALL, 0, 3, 1, 3);
      // RR wrap in set 5, set 6 untouched
      step(0, 0, 0, 1, 5, ALL, 0, 0, 0);
      step(0, 0, 0, 1, 5, ALL, 0, 1, 2);
      step(0, 0, 0, 1, 5, ALL, 0, 2, 1);
      step(0, 0, 0, 1, 5, ALL, 0, 3, 3);
      step(0, 0, 0, 1, 5, ALL, 0, 0, 0);
      step(0, 0, 0, 1, 6, ALL, 0, 0, 0);
      idle(3);

      // Reset while a request is in flight: no result may appear
      @(posedge clk);
      #1;
      req = 1'b1; vset = 6'd3; vvec = ALL;
      #2 rst_n = 1'b0;
      @(posedge clk);
      #1;
      req = 1'b0;
      reset_model();
      rst_n = 1'b1;
      check_reset();
      idle(2);

      // Flush with a concurrent request; the LFSR keeps running
      step(0, 0, 0, 1, 3, ALL, 0, 0, 0, 1);
      step(0, 0, 0, 1, 3, ALL, 0, 1, 2, 3);
      step(0, 0, 0, 1, 3, ALL, 1, 2, 1, 3);
      step(0, 0, 0, 1, 3, ALL, 0, 0, 0, 3);
      // Same-set hit and victim: the victim touch owns node 1
      step(1, 9, 1, 1, 9, ALL, 0, 0, 0);
      step(1, 9, 2, 0, 0, ALL, 0);
      step(0, 0, 0, 1, 9, ALL, 0, 1, 1);
      idle(2);

      for (int c = 0; c < 1500; c++) begin
         logic [3:0] vv;
         vv = ($urandom_range(0, 99) < 70) ? ALL : 4'($urandom);
         step(1'($urandom_range(0, 1)), int'($urandom_range(0, 7)), int'($urandom_range(0, 3)),
              $urandom_range(0, 99) < 60, int'($urandom_range(0, 7)), vv,
              $urandom_range(0, 99) < 3);
      end
      idle(4);

      for (int d = 0; d < NP; d++) chk({pname(d), " unanswered requests"}, exp_q[d].size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
